bp_be_fp_fwd_pipe: RTL

- FP completion/forwarding pipeline that sits directly upstream of the FP bypass network.
- Carries in-flight FP register writes through fwd_els_p stages and accepts late (long-latency) results at a fixed stage.
- Presents registered per-stage valid/addr/data vectors that drive the bypass forwarding inputs (stage 0 = youngest = highest bypass priority).
- Retires the oldest entry to the FP register file through a valid/ready port.

---
 rtl/bp_be_fp_fwd_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bp_be_fp_fwd_pipe.sv
// FP completion/forwarding pipe feeding the FP bypass network and the FP regfile write port.
// Optional NaN-boxing of single-precision results: define BP_BE_FP_FWD_NANBOX_EN.
module bp_be_fp_fwd_pipe #(
    parameter int fwd_els_p      = 4,
    parameter int late_stage_p   = 1,
    parameter int commit_stage_p = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      v_i,
    output logic                      ready_o,
    input  logic [4:0]                rd_addr_i,
    input  logic [63:0]               rd_data_i,
    input  logic                      rd_data_v_i,
    input  logic                      sp_i,

    input  logic                      late_v_i,
    input  logic [63:0]               late_data_i,

    input  logic                      flush_i,

    output logic [fwd_els_p-1:0]      fwd_rd_v_o,
    output logic [fwd_els_p*5-1:0]    fwd_rd_addr_o,
    output logic [fwd_els_p*64-1:0]   fwd_rd_o,

    output logic                      wb_v_o,
    input  logic                      wb_ready_i,
    output logic [4:0]                wb_addr_o,
    output logic [63:0]               wb_data_o
);

    localparam int unsigned last_lp = fwd_els_p - 1;

`ifdef BP_BE_FP_FWD_NANBOX_EN
    localparam bit nanbox_en_lp = 1'b1;
`else
    localparam bit nanbox_en_lp = 1'b0;
`endif

    logic [fwd_els_p-1:0] v_q, dv_q, sp_q;
    logic [4:0]           addr_q [fwd_els_p];
    logic [63:0]          data_q [fwd_els_p];

    logic [fwd_els_p-1:0] v_n, dv_n, sp_n;
    logic [4:0]           addr_n [fwd_els_p];
    logic [63:0]          data_n [fwd_els_p];

    logic        stall;
    logic        late_hit;
    int unsigned late_tgt;

    assign stall   = wb_v_o & ~wb_ready_i;
    assign ready_o = ~stall;

    assign late_hit = late_v_i & v_q[late_stage_p];
    assign late_tgt = stall ? late_stage_p : late_stage_p + 1;

    // Shift (or hold), then apply the late fill at the entry's post-shift position,
    // then flush the uncommitted stages of the resulting state.
    always_comb begin
        v_n    = v_q;
        dv_n   = dv_q;
        sp_n   = sp_q;
        addr_n = addr_q;
        data_n = data_q;

        if (!stall) begin
            v_n[0]    = v_i;
            dv_n[0]   = rd_data_v_i;
            sp_n[0]   = sp_i;
            addr_n[0] = rd_addr_i;
            data_n[0] = rd_data_i;
            for (int unsigned i = 1; i < fwd_els_p; i++) begin
                v_n[i]    = v_q[i-1];
                dv_n[i]   = dv_q[i-1];
                sp_n[i]   = sp_q[i-1];
                addr_n[i] = addr_q[i-1];
                data_n[i] = data_q[i-1];
            end
        end

        for (int unsigned i = 0; i < fwd_els_p; i++) begin
            if (late_hit && (i == late_tgt)) begin
                data_n[i] = late_data_i;
                dv_n[i]   = 1'b1;
            end
        end

        if (flush_i) begin
            for (int unsigned i = 0; i < commit_stage_p; i++) begin
                v_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q  <= '0;
            dv_q <= '0;
            sp_q <= '0;
            for (int unsigned i = 0; i < fwd_els_p; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            v_q    <= v_n;
            dv_q   <= dv_n;
            sp_q   <= sp_n;
            addr_q <= addr_n;
            data_q <= data_n;
        end
    end

    always_comb begin
        fwd_rd_v_o    = '0;
        fwd_rd_addr_o = '0;
        fwd_rd_o      = '0;
        for (int unsigned i = 0; i < fwd_els_p; i++) begin
            fwd_rd_v_o[i]          = v_q[i] & dv_q[i];
            fwd_rd_addr_o[i*5 +: 5] = addr_q[i];
            fwd_rd_o[i*64 +: 64]   = (nanbox_en_lp && sp_q[i])
                                     ? {32'hFFFF_FFFF, data_q[i][31:0]} : data_q[i];
        end
    end

    assign wb_v_o    = v_q[last_lp] & dv_q[last_lp];
    assign wb_addr_o = addr_q[last_lp];
    assign wb_data_o = fwd_rd_o[last_lp*64 +: 64];

    a_no_double_completion: assert property (@(posedge clk_i) disable iff (reset_i)
        !(late_v_i && v_q[late_stage_p] && dv_q[late_stage_p]));

    a_no_pending_writeback: assert property (@(posedge clk_i) disable iff (reset_i)
        !(v_q[last_lp] && !dv_q[last_lp]));

endmodule
